// File: rtl/dmem_arbiter_if.sv
// Bus bundle tying the two data-memory requesters (C and D), the arbiter and the memory together.
interface dmem_arbiter_if #(
  parameter int DM_ADDRESS = 9,
  parameter int DATA_W     = 32
);
  logic                  c_req, c_we, c_gnt, c_err, c_rvalid;
  logic [DM_ADDRESS-1:0] c_addr;
  logic [DATA_W-1:0]     c_wdata, c_rdata;
  logic [2:0]            c_funct3;

  logic                  d_req, d_we, d_gnt, d_err, d_rvalid;
  logic [DM_ADDRESS-1:0] d_addr;
  logic [DATA_W-1:0]     d_wdata, d_rdata;
  logic [2:0]            d_funct3;

  logic [DM_ADDRESS-1:0] m_addr;
  logic [DATA_W-1:0]     m_wdata, m_rdata;
  logic [3:0]            m_wr;

  modport master (
    output c_req, c_we, c_addr, c_wdata, c_funct3,
    output d_req, d_we, d_addr, d_wdata, d_funct3,
    output m_rdata,
    input  c_gnt, c_err, c_rvalid, c_rdata,
    input  d_gnt, d_err, d_rvalid, d_rdata,
    input  m_addr, m_wdata, m_wr
  );

  modport slave (
    input  c_req, c_we, c_addr, c_wdata, c_funct3,
    input  d_req, d_we, d_addr, d_wdata, d_funct3,
    input  m_rdata,
    output c_gnt, c_err, c_rvalid, c_rdata,
    output d_gnt, d_err, d_rvalid, d_rdata,
    output m_addr, m_wdata, m_wr
  );
endinterface

// File: rtl/dmem_arbiter.sv
// Data-memory arbiter between the pipeline MEM stage (C) and the DMA/debug loader (D).
// Define DMEM_ARB_RR_EN for strict round-robin; otherwise C has priority with a D starvation limit.
module dmem_arbiter #(
  parameter int DM_ADDRESS = 9,
  parameter int DATA_W     = 32,
  parameter int MAX_WAIT   = 8
) (
  input  logic          clk,
  input  logic          reset,
  dmem_arbiter_if.slave bus
);

  typedef enum logic { PORT_C = 1'b0, PORT_D = 1'b1 } port_e;

  function automatic logic is_illegal(input logic we, input logic [2:0] funct3,
                                      input logic [1:0] lane);
    case (funct3)
      3'b000:         is_illegal = 1'b0;
      3'b001:         is_illegal = lane[0];
      3'b010:         is_illegal = (lane != 2'b00);
      3'b100:         is_illegal = we;
      3'b101:         is_illegal = we | lane[0];
      default:        is_illegal = 1'b1;
    endcase
  endfunction

  logic                  c_gnt, d_gnt, pick_d, any_gnt;
  logic                  sel_we, sel_err, issue, load_issue;
  logic [DM_ADDRESS-1:0] sel_addr;
  logic [DATA_W-1:0]     sel_wdata, lane_word, load_data;
  logic [2:0]            sel_funct3;
  logic [1:0]            lane;

  port_e                 resp_port;
  logic                  resp_load;
  logic [DATA_W-1:0]     c_rdata_q, d_rdata_q;

`ifdef DMEM_ARB_RR_EN
  port_e                 rr_ptr;
`else
  logic [3:0]            wait_cnt;
`endif

  // A lone requester always wins; only a conflict consults the arbitration state.
  always_comb begin
    pick_d = 1'b0;
    c_gnt  = 1'b0;
    d_gnt  = 1'b0;
    if (!reset) begin
      if (bus.c_req && bus.d_req) begin
`ifdef DMEM_ARB_RR_EN
        pick_d = (rr_ptr == PORT_D);
`else
        pick_d = (wait_cnt == 4'(MAX_WAIT));
`endif
      end else begin
        pick_d = bus.d_req;
      end
      d_gnt = bus.d_req && pick_d;
      c_gnt = bus.c_req && !pick_d;
    end
  end

  assign any_gnt    = c_gnt | d_gnt;
  assign sel_we     = d_gnt ? bus.d_we     : bus.c_we;
  assign sel_addr   = d_gnt ? bus.d_addr   : bus.c_addr;
  assign sel_wdata  = d_gnt ? bus.d_wdata  : bus.c_wdata;
  assign sel_funct3 = d_gnt ? bus.d_funct3 : bus.c_funct3;
  assign lane       = sel_addr[1:0];
  assign sel_err    = any_gnt & is_illegal(sel_we, sel_funct3, lane);
  assign issue      = any_gnt & ~sel_err;
  assign load_issue = issue & ~sel_we;

  assign bus.c_gnt = c_gnt;
  assign bus.d_gnt = d_gnt;
  assign bus.c_err = c_gnt & sel_err;
  assign bus.d_err = d_gnt & sel_err;

  // Narrow stores replicate their data across lanes so the write mask alone selects the bytes.
  always_comb begin
    bus.m_addr  = '0;
    bus.m_wr    = 4'b0000;
    bus.m_wdata = '0;
    if (issue) begin
      bus.m_addr = {sel_addr[DM_ADDRESS-1:2], 2'b00};
      if (sel_we) begin
        case (sel_funct3)
          3'b000: begin
            bus.m_wr    = 4'b0001 << lane;
            bus.m_wdata = {4{sel_wdata[7:0]}};
          end
          3'b001: begin
            bus.m_wr    = 4'b0011 << lane;
            bus.m_wdata = {2{sel_wdata[15:0]}};
          end
          default: begin
            bus.m_wr    = 4'b1111;
            bus.m_wdata = sel_wdata;
          end
        endcase
      end
    end
  end

  assign lane_word = bus.m_rdata >> {lane, 3'b000};

  always_comb begin
    case (sel_funct3)
      3'b000:  load_data = {{24{lane_word[7]}}, lane_word[7:0]};
      3'b001:  load_data = {{16{lane_word[15]}}, lane_word[15:0]};
      3'b100:  load_data = {24'b0, lane_word[7:0]};
      3'b101:  load_data = {16'b0, lane_word[15:0]};
      default: load_data = lane_word;
    endcase
  end

  // Response routing: remember which port took a load so only its rvalid rises next cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      resp_load <= 1'b0;
      resp_port <= PORT_C;
      c_rdata_q <= '0;
      d_rdata_q <= '0;
    end else begin
      resp_load <= load_issue;
      resp_port <= d_gnt ? PORT_D : PORT_C;
      if (load_issue && c_gnt) c_rdata_q <= load_data;
      if (load_issue && d_gnt) d_rdata_q <= load_data;
    end
  end

`ifdef DMEM_ARB_RR_EN
  always_ff @(posedge clk) begin
    if (reset)      rr_ptr <= PORT_C;
    else if (c_gnt) rr_ptr <= PORT_D;
    else if (d_gnt) rr_ptr <= PORT_C;
  end
`else
  always_ff @(posedge clk) begin
    if (reset)                    wait_cnt <= 4'd0;
    else if (bus.d_req && !d_gnt) wait_cnt <= wait_cnt + 4'd1;
    else                          wait_cnt <= 4'd0;
  end
`endif

  // Reset drops any in-flight response and holds all outputs at zero.
  assign bus.c_rvalid = !reset && resp_load && (resp_port == PORT_C);
  assign bus.d_rvalid = !reset && resp_load && (resp_port == PORT_D);
  assign bus.c_rdata  = reset ? '0 : c_rdata_q;
  assign bus.d_rdata  = reset ? '0 : d_rdata_q;

endmodule
